// File: rtl/basket_receipt_reader.sv
// Checkout reader: walks the basket, converts each price to 5-digit BCD by double-dabble
// and streams one record per entry plus a grand-total record over a valid/ready link.
module basket_receipt_reader #(
    parameter int MAX_ITEMS = 12,
    parameter int PRICE_W   = 16
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic                           START,
    input  logic                           ABORT,
    input  logic [3:0]                     NUM,
    input  logic [PRICE_W-1:0]             T_PRICE,
    input  logic [4*MAX_ITEMS-1:0]         P_LIST_FLAT,
    input  logic [4*MAX_ITEMS-1:0]         QTT_LIST_FLAT,
    input  logic [PRICE_W*MAX_ITEMS-1:0]   PRICE_LIST_FLAT,
    input  logic                           REC_READY,
    output logic                           REC_VALID,
    output logic [3:0]                     REC_INDEX,
    output logic [3:0]                     REC_ID,
    output logic [3:0]                     REC_QTT,
    output logic [19:0]                    REC_PRICE_BCD,
    output logic                           REC_LAST,
    output logic                           BUSY,
    output logic                           DONE
);

    typedef enum logic [2:0] {IDLE, FETCH, CONVERT, PRESENT, FINISH} state_t;

    localparam int BCD_W = 20;

    state_t             state;
    logic [3:0]         idx;
    logic [3:0]         num_snap;
    logic [PRICE_W-1:0] tot_snap;
    logic [PRICE_W-1:0] bin_sr;
    logic [BCD_W-1:0]   bcd_sr;
    logic [4:0]         cnt;

    // Add-3 correction applied to every BCD digit of 5 or more before each shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int d = 0; d < BCD_W/4; d++) begin
            if (r[4*d +: 4] >= 4'd5)
                r[4*d +: 4] = r[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            idx           <= '0;
            num_snap      <= '0;
            tot_snap      <= '0;
            bin_sr        <= '0;
            bcd_sr        <= '0;
            cnt           <= '0;
            REC_VALID     <= 1'b0;
            REC_INDEX     <= '0;
            REC_ID        <= '0;
            REC_QTT       <= '0;
            REC_PRICE_BCD <= '0;
            REC_LAST      <= 1'b0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
        end else if (ABORT) begin
            state     <= IDLE;
            REC_VALID <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        num_snap <= (NUM > 4'(MAX_ITEMS)) ? 4'(MAX_ITEMS) : NUM;
                        tot_snap <= T_PRICE;
                        idx      <= '0;
                        BUSY     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (idx < num_snap) begin
                        REC_INDEX <= idx;
                        REC_ID    <= P_LIST_FLAT[4*idx +: 4];
                        REC_QTT   <= QTT_LIST_FLAT[4*idx +: 4];
                        bin_sr    <= PRICE_LIST_FLAT[PRICE_W*idx +: PRICE_W];
                        REC_LAST  <= 1'b0;
                    end else begin
                        REC_INDEX <= 4'hF;
                        REC_ID    <= 4'hF;
                        REC_QTT   <= 4'h0;
                        bin_sr    <= tot_snap;
                        REC_LAST  <= 1'b1;
                    end
                    bcd_sr <= '0;
                    cnt    <= '0;
                    state  <= CONVERT;
                end
                // One double-dabble step per cycle; the finished digits are published on the
                // cycle after the last shift.
                CONVERT: begin
                    if (cnt == 5'(PRICE_W)) begin
                        REC_PRICE_BCD <= bcd_sr;
                        REC_VALID     <= 1'b1;
                        state         <= PRESENT;
                    end else begin
                        {bcd_sr, bin_sr} <= {dd_adjust(bcd_sr), bin_sr} << 1;
                        cnt              <= cnt + 5'd1;
                    end
                end
                PRESENT: begin
                    if (REC_READY) begin
                        REC_VALID <= 1'b0;
                        if (REC_LAST) begin
                            DONE  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
